// File: rtl/div_sched.sv
// Round-robin front end that lets NREQ requesters share one iterative divider.
// One operation is in flight at a time; the result is held until the consumer takes it.
module div_sched #(
  parameter int WIDTH = 9,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_q,
  output logic [WIDTH-1:0]      resp_r,
  output logic                  resp_dbz,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_x,
  output logic [WIDTH-1:0]      div_y,
  input  logic                  div_busy,
  input  logic                  div_valid,
  input  logic                  div_dbz,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] x_arr [NREQ];
  logic [WIDTH-1:0] y_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*WIDTH +: WIDTH];
    assign y_arr[g] = req_y[g*WIDTH +: WIDTH];
  end

  // Round-robin arbiter: first set req_valid bit at or after last_grant+1.
  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand_idx;
  logic            grant_found;
  int              cand;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found        = 1'b1;
        grant_idx          = cand_idx;
        grant_oh[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    x_d          = x_q;
    y_d          = y_q;
    q_d          = q_q;
    r_d          = r_q;
    dbz_d        = dbz_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          x_d          = x_arr[grant_idx];
          y_d          = y_arr[grant_idx];
          state_d      = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Divider flags are only trusted here, after the start pulse has cleared them.
        if (div_valid) begin
          q_d     = div_q;
          r_d     = div_r;
          dbz_d   = 1'b0;
          state_d = RESP;
        end else if (!div_busy && div_dbz) begin
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      q_q          <= '0;
      r_q          <= '0;
      dbz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      x_q          <= x_d;
      y_q          <= y_d;
      q_q          <= q_d;
      r_q          <= r_d;
      dbz_q        <= dbz_d;
    end
  end

  // Outputs are forced to zero for every cycle rst is high, including the first one.
  assign req_ready  = (!rst && state_q == IDLE) ? grant_oh : '0;
  assign div_start  = !rst && (state_q == START);
  assign resp_valid = !rst && (state_q == RESP);
  assign resp_id    = rst ? '0 : id_q;
  assign resp_q     = rst ? '0 : q_q;
  assign resp_r     = rst ? '0 : r_q;
  assign resp_dbz   = !rst && dbz_q;
  assign div_x      = rst ? '0 : x_q;
  assign div_y      = rst ? '0 : y_q;

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the operand width of the shared divider.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8); IDW = $clog2(NREQ).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester divide request.
- req_ready  output  NREQ  per-requester accept, at most one bit set.
- req_x  input  NREQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH].
- req_y  input  NREQ*WIDTH  divisors, same packing.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_q  output  WIDTH  quotient.
- resp_r  output  WIDTH  remainder.
- resp_dbz  output  1  divide-by-zero; resp_q and resp_r are 0 when set.
- div_start  output  1  one-cycle start pulse to the divider.
- div_x  output  WIDTH  dividend to the divider.
- div_y  output  WIDTH  divisor to the divider.
- div_busy  input  1  divider busy.
- div_valid  input  1  divider result valid (level).
- div_dbz  input  1  divider divide-by-zero flag (level).
- div_q  input  WIDTH  divider quotient.
- div_r  input  WIDTH  divider remainder.

Function
REQ-004 The FSM SHALL have four states: IDLE, START, WAIT, RESP.
REQ-005 In IDLE, req_ready SHALL be one-hot on the round-robin winner among the set req_valid bits; it SHALL be all-zero when no req_valid bit is set or the state is not IDLE.
REQ-006 Round-robin SHALL search from index (last_grant+1) mod NREQ upward with wrap-around; last_grant SHALL update on every accept.
REQ-007 On accept (req_valid[i] and req_ready[i]), the block SHALL capture req_x/req_y slice i into div_x/div_y registers and i into resp_id, then go to START.
REQ-008 In START, div_start SHALL be 1 for exactly one cycle; div_x/div_y SHALL stay stable from START until the next accept; the next state SHALL be WAIT.
REQ-009 In WAIT, if div_valid=1, the block SHALL register resp_q=div_q, resp_r=div_r, resp_dbz=0 and go to RESP.
REQ-010 In WAIT, if div_valid=0, div_busy=0 and div_dbz=1, the block SHALL register resp_q=0, resp_r=0, resp_dbz=1 and go to RESP.
REQ-011 Divider flags SHALL be sampled only in WAIT, which starts the cycle after div_start; stale div_valid/div_dbz from earlier operations SHALL never be used.
REQ-012 In RESP, resp_valid SHALL be 1; resp_id/q/r/dbz SHALL be held stable until resp_ready=1; on resp_valid and resp_ready the next state SHALL be IDLE.
REQ-013 Latency SHALL be as follows, with the accept on the edge ending cycle T:
- div_start is asserted in cycle T+1.
- With y!=0, div_valid is sampled first in cycle T+1+WIDTH and resp_valid is asserted from cycle T+2+WIDTH.
- With y=0, resp_valid is asserted from cycle T+3.
REQ-014 Only one operation SHALL be outstanding; requests arriving during START/WAIT/RESP SHALL wait with req_ready=0 and need not be held by the block.
REQ-015 A requester that drops req_valid before acceptance SHALL be skipped with no side effect.
REQ-016 With resp_ready held at 1 and requests pending, IDLE SHALL last exactly one cycle between operations.

Reset
REQ-017 While rst=1, the block SHALL drive req_ready=0, div_start=0, resp_valid=0, resp_id=0, resp_q=0, resp_r=0, resp_dbz=0, div_x=0 and div_y=0; state SHALL be IDLE and last_grant SHALL be NREQ-1 (so requester 0 wins first).
REQ-018 A reset during START/WAIT/RESP SHALL abandon the operation with no response; the divider has no reset, and its later div_valid SHALL be ignored per REQ-011.

Verification
REQ-019 A bench SHALL cover these directed scenarios (WIDTH=9, NREQ=4, divider model attached):
- Requester 1 sends x=100, y=7 with resp_ready=1 -> resp_valid in cycle T+11, resp_id=1, q=14, r=2, dbz=0.
- Requester 2 sends x=5, y=0 -> resp_valid in cycle T+3, resp_id=2, dbz=1, q=0, r=0.
- All four requesters hold req_valid after reset -> grant order 0,1,2,3,0; each resp_id matches its operands.
- Hold resp_ready=0 for 20 cycles after resp_valid -> outputs stable, req_ready=0, no div_start pulse; release -> IDLE next cycle.
- Assert rst in WAIT, then issue a new request x=9, y=3 -> no stale response appears; new response q=3, r=0.
- x=511, y=1 -> q=511, r=0; then x=3, y=10 -> q=0, r=3.
